// File: rtl/axi_sram_master.sv
// Single-beat AXI4 master bridging an SRAM-style request/response client.
// One transaction outstanding at a time; reads and writes use fixed INCR, length-1 bursts.
module axi_sram_master #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        s_aclk,
    input  logic        s_aresetn,

    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_err,

    output logic [3:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [3:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [3:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        aw_done, w_done;
    logic        aw_done_nxt, w_done_nxt;
    logic        r_hs, b_hs;

    // Response IDs and rlast carry no information for a single outstanding beat.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, m_axi_bid, m_axi_rlast};

    always_comb begin
        state_nxt     = state;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        addr_ok       = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                addr_ok     = 1'b1;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (req) state_nxt = wr ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_nxt = IDLE;
            end
            WR_ADDR: begin
                // AW and W retire independently; leave once both have, even in the same cycle.
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if (m_axi_awvalid && m_axi_awready) aw_done_nxt = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_nxt  = 1'b1;
                if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign r_hs = m_axi_rready && m_axi_rvalid;
    assign b_hs = m_axi_bready && m_axi_bvalid;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            data_ok  <= 1'b0;
            resp_err <= 1'b0;
            rdata    <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            data_ok <= r_hs || b_hs;
            if (r_hs) begin
                rdata    <= m_axi_rdata;
                resp_err <= |m_axi_rresp;
            end
            if (b_hs) resp_err <= |m_axi_bresp;
            if (req && addr_ok) begin
                size_q  <= size;
                addr_q  <= addr;
                wstrb_q <= wstrb;
                wdata_q <= wdata;
            end
        end
    end

    assign m_axi_awid    = WR_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = {1'b0, size_q};
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;

    assign m_axi_arid    = RD_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = {1'b0, size_q};
    assign m_axi_arburst = 2'b01;

endmodule

// File: tb/tb_axi_sram_master.sv
// Self-checking bench for axi_sram_master: directed latency cases, reset abort,
// then randomized mixed traffic against a client-side memory model.
module tb_axi_sram_master;

    localparam logic [3:0] T_RD_ID = 4'd3;
    localparam logic [3:0] T_WR_ID = 4'd5;

    logic        s_aclk = 1'b0;
    logic        s_aresetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, resp_err;
    logic [31:0] rdata;
    logic [3:0]  m_axi_awid, m_axi_arid, m_axi_wstrb, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] slv_mem [64];
    logic [31:0] last_rdata;

    always #5 s_aclk = ~s_aclk;

    axi_sram_master #(.RD_ID(T_RD_ID), .WR_ID(T_WR_ID)) dut (
        .s_aclk(s_aclk), .s_aresetn(s_aresetn),
        .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .resp_err(resp_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ready/valid decision for cycle k: random when s < 0, else asserted from cycle s onward.
    function automatic logic sched(input int s, input int k);
        if (s < 0) return 1'($urandom_range(0, 1));
        return k >= s;
    endfunction

    function automatic logic [1:0] pick_resp(input int m);
        if (m >= 0) return 2'(m);
        if ($urandom_range(0, 7) == 0) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    task automatic clear_slave();
        m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_rvalid  = 1'b0; m_axi_bvalid  = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the data_ok cycle.
    task automatic run_txn(input logic t_wr, input logic [1:0] t_size, input logic [31:0] t_addr,
                           input logic [3:0] t_wstrb, input logic [31:0] t_wdata,
                           input int ar_s, input int r_s, input int aw_s, input int w_s,
                           input int b_s, input int err_m, output int done_cyc);
        logic ar_d, aw_d, w_d, rsp_d, hs_ar, hs_aw, hs_w, hs_rsp, exp_err;
        logic [31:0] exp_rd, s_araddr, s_awaddr, s_wdata;
        logic [3:0]  s_wstrb;
        logic [5:0]  ix;
        ar_d = 0; aw_d = 0; w_d = 0; rsp_d = 0;
        hs_ar = 0; hs_aw = 0; hs_w = 0; hs_rsp = 0; exp_err = 0;
        s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
        done_cyc = -1;
        ix = t_addr[7:2];
        if (t_wr) begin
            for (int b = 0; b < 4; b++)
                if (t_wstrb[b]) ref_mem[ix][8*b +: 8] = t_wdata[8*b +: 8];
            exp_rd = last_rdata;
        end else begin
            exp_rd = ref_mem[ix];
        end
        req = 1'b1; wr = t_wr; size = t_size; addr = t_addr; wstrb = t_wstrb; wdata = t_wdata;
        chk("addr_ok_idle", 32'(addr_ok), 32'(1));
        @(negedge s_aclk);
        req = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (hs_ar) ar_d = 1'b1;
            if (hs_aw) aw_d = 1'b1;
            if (hs_w)  w_d  = 1'b1;
            if (hs_rsp) rsp_d = 1'b1;
            chk("data_ok", 32'(data_ok), 32'(rsp_d));
            chk("addr_ok_busy", 32'(addr_ok), 32'(rsp_d));
            chk("arvalid", 32'(m_axi_arvalid), 32'(!t_wr && !ar_d));
            chk("rready",  32'(m_axi_rready),  32'(!t_wr && ar_d && !rsp_d));
            chk("awvalid", 32'(m_axi_awvalid), 32'(t_wr && !aw_d));
            chk("wvalid",  32'(m_axi_wvalid),  32'(t_wr && !w_d));
            chk("bready",  32'(m_axi_bready),  32'(t_wr && aw_d && w_d && !rsp_d));
            if (!t_wr && !ar_d) begin
                chk("araddr",  m_axi_araddr, t_addr);
                chk("arsize",  32'(m_axi_arsize), 32'({1'b0, t_size}));
                chk("arid",    32'(m_axi_arid), 32'(T_RD_ID));
                chk("arlen",   32'(m_axi_arlen), 32'(0));
                chk("arburst", 32'(m_axi_arburst), 32'(1));
            end
            if (t_wr && !aw_d) begin
                chk("awaddr",  m_axi_awaddr, t_addr);
                chk("awsize",  32'(m_axi_awsize), 32'({1'b0, t_size}));
                chk("awid",    32'(m_axi_awid), 32'(T_WR_ID));
                chk("awlen",   32'(m_axi_awlen), 32'(0));
                chk("awburst", 32'(m_axi_awburst), 32'(1));
            end
            if (t_wr && !w_d) begin
                chk("wdata", m_axi_wdata, t_wdata);
                chk("wstrb", 32'(m_axi_wstrb), 32'(t_wstrb));
                chk("wlast", 32'(m_axi_wlast), 32'(1));
            end
            if (rsp_d) begin
                chk("rdata", rdata, exp_rd);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                done_cyc = k;
                break;
            end
            m_axi_arready = !t_wr && !ar_d && sched(ar_s, k);
            m_axi_awready = t_wr && !aw_d && sched(aw_s, k);
            m_axi_wready  = t_wr && !w_d && sched(w_s, k);
            m_axi_rid = 4'($urandom); m_axi_bid = 4'($urandom);
            m_axi_rlast = 1'($urandom);
            if (!t_wr && ar_d && !m_axi_rvalid && sched(r_s, k)) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = slv_mem[s_araddr[7:2]];
                m_axi_rresp  = pick_resp(err_m);
                exp_err      = |m_axi_rresp;
            end
            if (t_wr && aw_d && w_d && !m_axi_bvalid && sched(b_s, k)) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) slv_mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = pick_resp(err_m);
                exp_err      = |m_axi_bresp;
            end
            hs_ar = m_axi_arvalid && m_axi_arready;
            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid && m_axi_wready;
            hs_rsp = (m_axi_rready && m_axi_rvalid) || (m_axi_bready && m_axi_bvalid);
            if (hs_ar) s_araddr = m_axi_araddr;
            if (hs_aw) s_awaddr = m_axi_awaddr;
            if (hs_w) begin s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
            @(negedge s_aclk);
        end
        chk("completed", 32'(done_cyc > 0), 32'(1));
        clear_slave();
        if (!t_wr && done_cyc > 0) last_rdata = exp_rd;
    endtask

    initial begin
        int dc;
        logic rw;
        logic [31:0] ra;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        last_rdata = '0;
        req = 0; wr = 0; size = 0; addr = 0; wstrb = 0; wdata = 0;
        m_axi_bid = 0; m_axi_bresp = 0; m_axi_rid = 0; m_axi_rdata = 0;
        m_axi_rresp = 0; m_axi_rlast = 0;
        clear_slave();
        s_aresetn = 1'b0;

        // Reset state
        repeat (2) @(negedge s_aclk);
        chk("rst_addr_ok", 32'(addr_ok), 32'(1));
        chk("rst_data_ok", 32'(data_ok), 32'(0));
        chk("rst_resp_err", 32'(resp_err), 32'(0));
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'(0));
        chk("rst_awvalid", 32'(m_axi_awvalid), 32'(0));
        chk("rst_wvalid", 32'(m_axi_wvalid), 32'(0));
        chk("rst_rready", 32'(m_axi_rready), 32'(0));
        chk("rst_bready", 32'(m_axi_bready), 32'(0));
        s_aresetn = 1'b1;
        @(negedge s_aclk);

        // Minimum-latency read
        ref_mem[0] = 32'hDEADBEEF; slv_mem[0] = 32'hDEADBEEF;
        run_txn(1'b0, 2'd2, 32'h1FC0_0000, 4'hF, 32'h0, 1, 1, -1, -1, -1, 0, dc);
        chk("rd_latency", 32'(dc), 32'(3));
        chk("rd_value", rdata, 32'hDEADBEEF);

        // Write with staggered AW/W readiness and late response
        run_txn(1'b1, 2'd1, 32'h0000_0100, 4'b0011, 32'hCAFE_1234, -1, -1, 1, 4, 6, 0, dc);
        chk("wr_latency", 32'(dc), 32'(7));
        chk("wr_rdata_hold", rdata, 32'hDEADBEEF);

        // Read back the partial write, then a slave error on read
        run_txn(1'b0, 2'd2, 32'h0000_0100, 4'hF, 32'h0, -1, -1, -1, -1, -1, 0, dc);
        run_txn(1'b0, 2'd2, 32'h0000_0104, 4'hF, 32'h0, 1, 1, -1, -1, -1, 2, dc);
        chk("err_resp_err", 32'(resp_err), 32'(1));
        @(negedge s_aclk);
        chk("err_idle", 32'(addr_ok), 32'(1));
        chk("err_single_pulse", 32'(data_ok), 32'(0));

        // Reset mid-read while waiting for R
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0040;
        @(negedge s_aclk);
        req = 1'b0; m_axi_arready = 1'b1;
        @(negedge s_aclk);
        m_axi_arready = 1'b0;
        chk("abort_rready_pre", 32'(m_axi_rready), 32'(1));
        #2 s_aresetn = 1'b0;
        #1;
        chk("abort_arvalid", 32'(m_axi_arvalid), 32'(0));
        chk("abort_rready", 32'(m_axi_rready), 32'(0));
        chk("abort_addr_ok", 32'(addr_ok), 32'(1));
        chk("abort_rdata", rdata, 32'h0);
        last_rdata = '0;
        repeat (2) begin
            @(negedge s_aclk);
            chk("abort_data_ok", 32'(data_ok), 32'(0));
        end
        s_aresetn = 1'b1;
        @(negedge s_aclk);
        chk("abort_post_data_ok", 32'(data_ok), 32'(0));
        run_txn(1'b0, 2'd2, 32'h0000_0040, 4'hF, 32'h0, -1, -1, -1, -1, -1, 0, dc);

        // Random mixed traffic with random ready/valid masks
        for (int n = 0; n < 1000; n++) begin
            rw = 1'($urandom);
            ra = $urandom;
            run_txn(rw, 2'($urandom_range(0, 2)), ra, 4'($urandom_range(1, 15)), $urandom,
                    -1, -1, -1, -1, -1, -1, dc);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge s_aclk);
                chk("gap_data_ok", 32'(data_ok), 32'(0));
                chk("gap_addr_ok", 32'(addr_ok), 32'(1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_master.md
AXI_SRAM_MASTER -- requirements
Module: axi_sram_master

Interface
REQ-001 Parameter RD_ID, default 4'd0, SHALL be the arid driven on every read.
REQ-002 Parameter WR_ID, default 4'd1, SHALL be the awid driven on every write.
REQ-003 s_aclk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 s_aresetn  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  client request valid.
REQ-006 wr  in  1  1 = write, 0 = read.
REQ-007 size  in  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-008 addr  in  32  byte address.
REQ-009 wstrb  in  4  write byte enables.
REQ-010 wdata  in  32  write data.
REQ-011 addr_ok  out  1  request accepted this cycle when req is also 1.
REQ-012 data_ok  out  1  one-cycle completion pulse.
REQ-013 rdata  out  32  read data, valid while data_ok = 1 for a read.
REQ-014 resp_err  out  1  valid with data_ok; 1 when rresp/bresp != 2'b00.
REQ-015 AW channel: m_axi_awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1 out; awready 1 in.
REQ-016 W channel: m_axi_wdata 32, wstrb 4, wlast 1, wvalid 1 out; wready 1 in.
REQ-017 B channel: m_axi_bid 4, bresp 2, bvalid 1 in; bready 1 out.
REQ-018 AR channel: m_axi_arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 out; arready 1 in.
REQ-019 R channel: m_axi_rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 in; rready 1 out.

Function
REQ-020 States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP; at most one transaction outstanding.
REQ-021 addr_ok SHALL equal (state == IDLE), combinationally.
REQ-022 On req & addr_ok: latch wr, size, addr, wstrb, wdata; go to RD_ADDR (wr = 0) or WR_ADDR (wr = 1).
REQ-023 RD_ADDR: arvalid = 1, araddr and arsize from the latch; on arready -> RD_DATA.
REQ-024 RD_DATA: rready = 1; on rvalid: register rdata and resp_err, pulse data_ok in the next cycle, go to IDLE.
REQ-025 WR_ADDR: awvalid and wvalid rise together on entry. Each deasserts independently after its own handshake. Go to WR_RESP once both handshakes have completed, including the case where both complete in the same cycle.
REQ-026 WR_RESP: bready = 1; on bvalid: register resp_err, pulse data_ok in the next cycle, go to IDLE.
REQ-027 Fixed fields: awlen = arlen = 0; awburst = arburst = 2'b01; wlast = 1; awsize = arsize = {1'b0, size}.
REQ-028 Once raised, a valid SHALL stay high with stable payload until its ready is sampled high; there is no withdrawal.
REQ-029 rready and bready SHALL be 0 outside RD_DATA and WR_RESP respectively.
REQ-030 rid, bid and rlast are ignored; a response is accepted regardless of its ID.
REQ-031 Minimum latency, acceptance at cycle 0 with ready/response asserted as early as possible: valid at cycle 1, rready/bready at cycle 2, data_ok at cycle 3.
REQ-032 data_ok is high for exactly one cycle per accepted request. A new request may be accepted in the same cycle as data_ok, because the state is already IDLE.
REQ-033 rdata SHALL hold its last value until the next read completes.

Reset
REQ-034 While s_aresetn = 0: state = IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok and resp_err = 0; rdata = 0.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately (asynchronously) with no data_ok. The first request after release is accepted normally.

Verification
REQ-036 Read, addr 0x1FC0_0000, size 2; arready and rvalid tied high; rdata 0xDEADBEEF -> arvalid at cycle 1, data_ok at cycle 3 with rdata 0xDEADBEEF and resp_err = 0.
REQ-037 Write, addr 0x100, wstrb 4'b0011; awready at cycle 1, wready delayed to cycle 4; bvalid at cycle 6 -> awvalid low from cycle 2, wvalid high during cycles 1-4, bready from cycle 5, data_ok at cycle 7.
REQ-038 Random 0/1 mask on every ready/valid input over 1000 mixed requests -> valids never drop before their handshake, one data_ok per request, read data matches a memory model.
REQ-039 rresp = 2'b10 on a read -> data_ok with resp_err = 1, then the FSM returns to IDLE.
REQ-040 s_aresetn pulsed low while in RD_DATA -> arvalid and rready = 0 at once, no data_ok, and the next read completes correctly.
